// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter and sequencer for a single-port
// synchronous RAM with a tristate data bus. Writes take one RAM cycle (WR).
// Reads take two RAM cycles (RD1 address/registration, RD2 data on the bus).
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration. When it is undefined, requester 0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  inout  logic [DATA_WIDTH-1:0]   ram_data,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic                    ram_oe
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t                state;
  logic                  id;
  logic                  drive;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  win_id;
  logic                  win_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic                  ptr;
`endif

  // Arbitration: a lone requester always wins; contention is resolved by
  // the round-robin pointer or by fixed priority.
  always_comb begin
    win_any = |req_valid;
    win_id  = 1'b0;
    if (req_valid == 2'b10) begin
      win_id = 1'b1;
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    else if (req_valid == 2'b11) begin
      win_id = ptr;
    end
`endif
  end

  assign sel_we    = win_id ? req_we[1] : req_we[0];
  assign sel_addr  = win_id ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                            : req_addr[0 +: ADDR_WIDTH];
  assign sel_wdata = win_id ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                            : req_wdata[0 +: DATA_WIDTH];

  // Accept is only offered while idle and out of reset.
  assign req_ready = (rst_n && (state == IDLE) && win_any)
                   ? (win_id ? 2'b10 : 2'b01) : '0;

  // The bus is driven only during WR; the enable is registered.
  assign ram_data = drive ? wdata_q : 'z;

  // Sequencer: strobes are set one edge ahead so every ram_* output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      id        <= 1'b0;
      drive     <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr       <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_ready) begin
            id       <= win_id;
            wdata_q  <= sel_wdata;
            ram_addr <= sel_addr;
            ram_cs   <= 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr      <= ~win_id;
`endif
            if (sel_we) begin
              ram_we <= 1'b1;
              drive  <= 1'b1;
              state  <= WR;
            end else begin
              ram_oe <= 1'b1;
              state  <= RD1;
            end
          end
        end
        WR: begin
          ram_cs        <= 1'b0;
          ram_we        <= 1'b0;
          drive         <= 1'b0;
          rsp_valid[id] <= 1'b1;
          state         <= IDLE;
        end
        RD1: begin
          state <= RD2;
        end
        RD2: begin
          rsp_rdata     <= ram_data;
          ram_cs        <= 1'b0;
          ram_oe        <= 1'b0;
          rsp_valid[id] <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plus random stimulus against a
// transaction-level reference model (handshake cycle -> expected strobes,
// response cycle and read data), with a behavioural RAM on the bus.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    rv, rwe;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs, ram_we, ram_oe;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(req_ready),
    .req_we(rwe), .req_addr({ra1, ra0}), .req_wdata({rd1, rd0}),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe));

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: registers the word at the end of RD1,
  // drives it during the following cycle.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q = '0;
  logic          ram_drv = 1'b0;
  assign ram_data = ram_drv ? ram_q : 'z;
  always @(posedge clk) begin
    ram_drv <= ram_cs && ram_oe && !ram_we;
    if (ram_cs && ram_oe && !ram_we) ram_q <= ram_mem[ram_addr];
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
  end

  // Reference model state (cycle-indexed transactions).
  int            checks = 0, errors = 0;
  int            cyc = 0, idle_at = 0, rsp_at = -1, op_start = 0;
  bit            op_active = 0, op_we = 0, rsp_read = 0, ptr = 0;
  bit            hs_seen = 0;
  int            hs_id = 0;
  logic [1:0]    rsp_oh = '0;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_data = '0, rsp_val = '0, last_rdata = '0;
  logic [DW-1:0] mem [256];
  int            obs_cnt [2], exp_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    return int'(ptr);
`else
    return 0;
`endif
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the model, move to next negedge.
  task automatic step(input bit do_chk);
    int         w;
    bit         idle, wr, rd1c, rd2c;
    logic [1:0] exp_ready, exp_rsp;
    #1;
    w    = pick(rv);
    idle = rst_n && (cyc >= idle_at);
    exp_ready = (idle && w >= 0) ? 2'(1 << w) : 2'b00;
    exp_rsp   = (cyc == rsp_at) ? rsp_oh : 2'b00;
    if (cyc == rsp_at && rsp_read) last_rdata = rsp_val;
    wr   = op_active && op_we  && (cyc == op_start + 1);
    rd1c = op_active && !op_we && (cyc == op_start + 1);
    rd2c = op_active && !op_we && (cyc == op_start + 2);
    if (do_chk) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
      chk("ram_cs", 32'(ram_cs), 32'(wr | rd1c | rd2c));
      chk("ram_we", 32'(ram_we), 32'(wr));
      chk("ram_oe", 32'(ram_oe), 32'(rd1c | rd2c));
      chk("oe_we_excl", 32'(ram_oe & ram_we), 32'd0);
      if (wr | rd1c | rd2c) chk("ram_addr", 32'(ram_addr), 32'(op_addr));
      if (wr)   chk("ram_data_wr", 32'(ram_data), 32'(op_data));
      if (rd2c) chk("ram_data_rd", 32'(ram_data), 32'(mem[op_addr]));
      for (int i = 0; i < 2; i++) begin
        obs_cnt[i] += int'(rsp_valid[i]);
        exp_cnt[i] += int'(exp_rsp[i]);
      end
    end
    hs_seen = 0;
    if (wr) mem[op_addr] = op_data;
    if (!rst_n) begin
      op_active = 0; rsp_at = -1; idle_at = cyc + 1; last_rdata = '0; ptr = 0;
    end else if (exp_ready != 2'b00) begin
      hs_seen   = 1;
      hs_id     = w;
      op_active = 1;
      op_start  = cyc;
      op_we     = rwe[w];
      op_addr   = (w == 1) ? ra1 : ra0;
      op_data   = (w == 1) ? rd1 : rd0;
      idle_at   = cyc + (op_we ? 2 : 3);
      rsp_at    = idle_at;
      rsp_oh    = 2'(1 << w);
      rsp_read  = !op_we;
      rsp_val   = mem[op_addr];
      ptr       = (w == 0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[id] = 1'b1; rwe[id] = we;
    if (id == 0) begin ra0 = a; rd0 = d; end else begin ra1 = a; rd1 = d; end
  endtask

  // Hold a request until the model sees it accepted (bounded), then drop it.
  task automatic hold_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    set_req(id, we, a, d);
    do begin
      step(1);
      n++;
    end while (!(hs_seen && hs_id == id) && n < 30);
    if (!(hs_seen && hs_id == id)) begin
      checks++; errors++;
      $error("FAIL hs_timeout: observed=none expected=handshake req%0d", id);
    end
    rv[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (cyc <= rsp_at && n < 10) begin step(1); n++; end
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram_mem[i] = '0; mem[i] = '0; end
    rst_n = 1'b0; rv = 2'b11; rwe = 2'b11; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    @(negedge clk);
    // Reset held three cycles with both requesters valid.
    step(0); step(1); step(1);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1; rv = 2'b00;

    // Single write then read from requester 0.
    hold_req(0, 1'b1, 8'h41, 8'hA5); drain();
    hold_req(0, 1'b0, 8'h41, 8'h00); drain();
    chk("rd_a5", 32'(rsp_rdata), 32'h0A5);

    // Contention: both requesters write continuously.
    obs_cnt = '{0, 0}; exp_cnt = '{0, 0};
    set_req(0, 1'b1, 8'h10, 8'h11);
    set_req(1, 1'b1, 8'h20, 8'h22);
    for (int i = 0; i < 16; i++) step(1);
    chk("cont_cnt0", 32'(obs_cnt[0]), 32'(exp_cnt[0]));
    chk("cont_cnt1", 32'(obs_cnt[1]), 32'(exp_cnt[1]));
    rv[0] = 1'b0;
    hold_req(1, 1'b1, 8'h20, 8'h22); drain();

    // Back-to-back write then read by the other requester.
    hold_req(0, 1'b1, 8'h41, 8'hA5);
    hold_req(1, 1'b0, 8'h41, 8'h00); drain();
    chk("b2b_rdata", 32'(rsp_rdata), 32'h0A5);

    // Random traffic on a small address window for read-after-write hits.
    for (int i = 0; i < 300; i++) begin
      rv  = 2'($urandom_range(0, 3));
      rwe = 2'($urandom_range(0, 3));
      ra0 = AW'($urandom_range(0, 15)); ra1 = AW'($urandom_range(0, 15));
      rd0 = DW'($urandom);              rd1 = DW'($urandom);
      step(1);
    end
    rv = 2'b00; drain();

    // Reset during RD2 aborts the read.
    hold_req(0, 1'b0, 8'h41, 8'h00);
    step(1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(1);
    chk("rst_mid_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    hold_req(0, 1'b0, 8'h41, 8'h00); drain();
    chk("post_rst_rd", 32'(rsp_rdata), 32'h0A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
